// File: rtl/axi_lite_pattern_master_if.sv
// AXI4-Lite bus bundle between the pattern master and the slave memory agent.
// Ports: AW/W/B/AR/R channel signals; master modport drives addresses, write data
// and response readies, slave modport drives readies, responses and read data.
interface axi_lite_pattern_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready
  );

  modport slave (
    input  awaddr, awprot, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input  araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/axi_lite_pattern_master.sv
// Purpose: AXI4-Lite traffic generator; writes N pattern words, reads them back, flags mismatches.
// Latency: 2 cycles per write and per read with a zero-wait slave; done flag 4N+1 cycles after start.
// Backpressure: every VALID/payload holds until its handshake; one transaction outstanding at a time.
// Ports: i_aclk/i_areset (sync, active-high), i_init_axi_txn (rising-edge start),
//        o_txn_done (level, until next start), o_error (sticky), m_axi (AXI4-Lite master modport).
module axi_lite_pattern_master #(
  parameter int                          C_M_AXI_ADDR_WIDTH         = 32,
  parameter int                          C_M_AXI_DATA_WIDTH         = 32,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_M_TARGET_SLAVE_BASE_ADDR = 32'h4000_0000,
  parameter int                          C_M_TRANSACTIONS_NUM       = 4,
  parameter logic [31:0]                 C_DATA_SEED                = 32'hA5A5_0000
) (
  input  logic                      i_aclk,
  input  logic                      i_areset,
  input  logic                      i_init_axi_txn,
  output logic                      o_txn_done,
  output logic                      o_error,
  axi_lite_pattern_master_if.master m_axi
);

  localparam int BSHIFT = $clog2(C_M_AXI_DATA_WIDTH / 8);
  localparam int IDX_W  = (C_M_TRANSACTIONS_NUM > 1) ? $clog2(C_M_TRANSACTIONS_NUM) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(C_M_TRANSACTIONS_NUM - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_ADDR, S_WR_RESP, S_RD_ADDR, S_RD_DATA, S_DONE
  } state_t;

  state_t                        r_state;
  state_t                        w_state_nxt;
  logic [IDX_W-1:0]              r_idx;
  logic                          r_aw_done;
  logic                          r_w_done;
  logic                          r_init_q;
  logic                          r_txn_done;
  logic                          r_error;

  logic                          w_start_ok;
  logic                          w_in_wr_addr;
  logic                          w_aw_hs;
  logic                          w_w_hs;
  logic                          w_wr_adv;
  logic                          w_b_hs;
  logic                          w_ar_hs;
  logic                          w_r_hs;
  logic                          w_last;
  logic                          w_rd_bad;
  logic [C_M_AXI_ADDR_WIDTH-1:0] w_addr;
  logic [C_M_AXI_DATA_WIDTH-1:0] w_pat;
  logic                          w_unused_ok;

  // Start is a rising edge of the request, only honoured when no sequence is running.
  assign w_start_ok   = i_init_axi_txn & ~r_init_q & ((r_state == S_IDLE) | (r_state == S_DONE));
  assign w_in_wr_addr = (r_state == S_WR_ADDR);
  // Handshakes are derived from state/flags rather than the driven VALIDs to keep the comb path acyclic.
  assign w_aw_hs      = w_in_wr_addr & ~r_aw_done & m_axi.awready;
  assign w_w_hs       = w_in_wr_addr & ~r_w_done & m_axi.wready;
  assign w_wr_adv     = w_in_wr_addr & (r_aw_done | w_aw_hs) & (r_w_done | w_w_hs);
  assign w_b_hs       = (r_state == S_WR_RESP) & m_axi.bvalid;
  assign w_ar_hs      = (r_state == S_RD_ADDR) & m_axi.arready;
  assign w_r_hs       = (r_state == S_RD_DATA) & m_axi.rvalid;
  assign w_last       = (r_idx == LAST_IDX);

  // Word i lives at base + i*bytes_per_word; the add wraps at the address width.
  assign w_addr   = C_M_TARGET_SLAVE_BASE_ADDR + (C_M_AXI_ADDR_WIDTH'(r_idx) << BSHIFT);
  assign w_pat    = C_M_AXI_DATA_WIDTH'(C_DATA_SEED + 32'(r_idx));
  assign w_rd_bad = (m_axi.rdata != w_pat) | m_axi.rresp[1];

  assign m_axi.awaddr = w_addr;
  assign m_axi.araddr = w_addr;
  assign m_axi.wdata  = w_pat;
  assign m_axi.awprot = 3'b000;
  assign m_axi.arprot = 3'b000;
  assign m_axi.wstrb  = '1;
  assign o_txn_done   = r_txn_done;
  assign o_error      = r_error;

  // Only the error bit of each response matters here.
  assign w_unused_ok = ^{m_axi.bresp[0], m_axi.rresp[0]};

  always_comb begin
    w_state_nxt   = r_state;
    m_axi.awvalid = 1'b0;
    m_axi.wvalid  = 1'b0;
    m_axi.bready  = 1'b0;
    m_axi.arvalid = 1'b0;
    m_axi.rready  = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_start_ok) w_state_nxt = S_WR_ADDR;
      end
      S_WR_ADDR: begin
        // AW and W complete independently; each VALID drops once its own beat is taken.
        m_axi.awvalid = ~r_aw_done;
        m_axi.wvalid  = ~r_w_done;
        if (w_wr_adv) w_state_nxt = S_WR_RESP;
      end
      S_WR_RESP: begin
        m_axi.bready = 1'b1;
        if (w_b_hs) w_state_nxt = w_last ? S_RD_ADDR : S_WR_ADDR;
      end
      S_RD_ADDR: begin
        m_axi.arvalid = 1'b1;
        if (w_ar_hs) w_state_nxt = S_RD_DATA;
      end
      S_RD_DATA: begin
        m_axi.rready = 1'b1;
        if (w_r_hs) w_state_nxt = w_last ? S_DONE : S_RD_ADDR;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_aclk) begin
    if (i_areset) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
      r_init_q   <= 1'b0;
      r_txn_done <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_init_q  <= i_init_axi_txn;
      r_aw_done <= w_in_wr_addr & ~w_wr_adv & (r_aw_done | w_aw_hs);
      r_w_done  <= w_in_wr_addr & ~w_wr_adv & (r_w_done | w_w_hs);
      if (w_start_ok) begin
        r_idx      <= '0;
        r_error    <= 1'b0;
        r_txn_done <= 1'b0;
      end else begin
        // Done is registered off the DONE state, so it rises one cycle after the last read.
        if (r_state == S_DONE) r_txn_done <= 1'b1;
        if (w_b_hs) begin
          if (m_axi.bresp[1]) r_error <= 1'b1;
          r_idx <= w_last ? '0 : r_idx + IDX_W'(1);
        end
        if (w_r_hs) begin
          if (w_rd_bad) r_error <= 1'b1;
          if (!w_last) r_idx <= r_idx + IDX_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_pattern_master.sv
// Bench for axi_lite_pattern_master: scripted AXI4-Lite slave memory, scoreboard of expected
// addresses/data pushed per sequence and popped by a monitor on each handshake, plus directed
// checks of done/error timing, reset abort and start-edge filtering.
module tb_axi_lite_pattern_master;

  localparam logic [31:0] EXP_ADDR [4] = '{32'h4000_0000, 32'h4000_0004, 32'h4000_0008, 32'h4000_000C};
  localparam logic [31:0] EXP_DATA [4] = '{32'hA5A5_0000, 32'hA5A5_0001, 32'hA5A5_0002, 32'hA5A5_0003};

  logic clk;
  logic areset;
  logic init;
  logic txn_done;
  logic error;

  int checks   = 0;
  int failures = 0;

  // Scoreboard queues and monitor counters.
  logic [31:0] exp_aw_q[$];
  logic [31:0] exp_w_q[$];
  logic [31:0] exp_ar_q[$];
  int aw_cnt = 0;
  int b_cnt  = 0;
  int r_cnt  = 0;

  // Slave behaviour knobs.
  int aw_delay    = 0;
  int w_delay     = 0;
  int corrupt_idx = -1;
  int berr_idx    = -1;
  logic [31:0] mem [16];

  axi_lite_pattern_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  axi_lite_pattern_master #(
    .C_M_AXI_ADDR_WIDTH        (32),
    .C_M_AXI_DATA_WIDTH        (32),
    .C_M_TARGET_SLAVE_BASE_ADDR(32'h4000_0000),
    .C_M_TRANSACTIONS_NUM      (4),
    .C_DATA_SEED               (32'hA5A5_0000)
  ) dut (
    .i_aclk        (clk),
    .i_areset      (areset),
    .i_init_axi_txn(init),
    .o_txn_done    (txn_done),
    .o_error       (error),
    .m_axi         (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int widx(input logic [31:0] a);
    logic [31:0] off;
    off = (a - 32'h4000_0000) >> 2;
    return int'(off[3:0]);
  endfunction

  // Slave memory agent: samples handshakes at negedge, drives new values just after posedge.
  initial begin : slave
    logic aw_p, w_p, b_p, ar_p, r_p, got_aw, got_w;
    logic [31:0] aw_a, w_d, ar_a, lat_aw, lat_w;
    int aw_wait, w_wait, ri;
    bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0; bus.bresp = 2'b00;
    bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rresp = 2'b00; bus.rdata = '0;
    got_aw = 1'b0; got_w = 1'b0; aw_wait = 0; w_wait = 0;
    lat_aw = '0; lat_w = '0;
    forever begin
      @(negedge clk);
      aw_p = bus.awvalid && bus.awready; aw_a = bus.awaddr;
      w_p  = bus.wvalid && bus.wready;   w_d  = bus.wdata;
      b_p  = bus.bvalid && bus.bready;
      ar_p = bus.arvalid && bus.arready; ar_a = bus.araddr;
      r_p  = bus.rvalid && bus.rready;
      @(posedge clk);
      #1;
      if (areset) begin
        bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0;
        bus.arready = 1'b0; bus.rvalid = 1'b0;
        got_aw = 1'b0; got_w = 1'b0; aw_wait = 0; w_wait = 0;
      end else begin
        if (aw_p) begin lat_aw = aw_a; got_aw = 1'b1; end
        if (w_p)  begin lat_w = w_d;   got_w  = 1'b1; end
        if (b_p) bus.bvalid = 1'b0;
        if (got_aw && got_w && !bus.bvalid) begin
          mem[widx(lat_aw)] = lat_w;
          bus.bresp  = (widx(lat_aw) == berr_idx) ? 2'b10 : 2'b00;
          bus.bvalid = 1'b1;
          got_aw = 1'b0; got_w = 1'b0;
        end
        if (r_p) bus.rvalid = 1'b0;
        if (ar_p) begin
          ri = widx(ar_a);
          bus.rdata  = mem[ri] + ((ri == corrupt_idx) ? 32'h10 : 32'h0);
          bus.rresp  = 2'b00;
          bus.rvalid = 1'b1;
        end
        bus.awready = bus.awvalid && (aw_wait >= aw_delay);
        aw_wait     = bus.awvalid ? aw_wait + 1 : 0;
        bus.wready  = bus.wvalid && (w_wait >= w_delay);
        w_wait      = bus.wvalid ? w_wait + 1 : 0;
        bus.arready = bus.arvalid;
      end
    end
  end

  // Monitor: pops expected values on each handshake and checks VALID/payload stability.
  initial begin : monitor
    logic aw_done_cur, w_hold;
    logic [31:0] w_hold_d;
    aw_done_cur = 1'b0; w_hold = 1'b0; w_hold_d = '0;
    forever begin
      @(negedge clk);
      if (areset) begin
        aw_done_cur = 1'b0; w_hold = 1'b0;
      end else begin
        if (w_hold) begin
          check("w_hold_vld", bus.wvalid, 1'b1);
          check("w_hold_dat", bus.wdata, w_hold_d);
        end
        if (aw_done_cur && bus.wvalid) check("aw_drop_after_hs", bus.awvalid, 1'b0);
        if (bus.awvalid && bus.awready) begin
          aw_cnt++;
          aw_done_cur = 1'b1;
          if (exp_aw_q.size() == 0) check("aw_unexpected", 1'b1, 1'b0);
          else check("awaddr", bus.awaddr, exp_aw_q.pop_front());
          check("awprot", bus.awprot, 3'b000);
        end
        if (bus.wvalid && bus.wready) begin
          if (exp_w_q.size() == 0) check("w_unexpected", 1'b1, 1'b0);
          else check("wdata", bus.wdata, exp_w_q.pop_front());
          check("wstrb", bus.wstrb, 4'hF);
        end
        w_hold   = bus.wvalid && !bus.wready;
        w_hold_d = bus.wdata;
        if (bus.bvalid && bus.bready) begin
          b_cnt++;
          aw_done_cur = 1'b0;
        end
        if (bus.arvalid && bus.arready) begin
          if (exp_ar_q.size() == 0) check("ar_unexpected", 1'b1, 1'b0);
          else check("araddr", bus.araddr, exp_ar_q.pop_front());
          check("arprot", bus.arprot, 3'b000);
        end
        if (bus.rvalid && bus.rready) r_cnt++;
      end
    end
  end

  task automatic push_seq();
    for (int i = 0; i < 4; i++) begin
      exp_aw_q.push_back(EXP_ADDR[i]);
      exp_w_q.push_back(EXP_DATA[i]);
      exp_ar_q.push_back(EXP_ADDR[i]);
    end
  endtask

  // Raises INIT for 20 ns; returns just after the edge following the one that samples start.
  task automatic pulse_init();
    @(posedge clk); #1;
    init = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    init = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (txn_done !== 1'b1 && n < 300);
    check(name, txn_done, 1'b1);
  endtask

  task automatic check_drained(input string name);
    check({name, "_aw_q"}, exp_aw_q.size(), 0);
    check({name, "_w_q"},  exp_w_q.size(), 0);
    check({name, "_ar_q"}, exp_ar_q.size(), 0);
  endtask

  initial begin : main
    int b_base, r_base, aw_base, rn, n;
    areset = 1'b1;
    init   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_awvalid", bus.awvalid, 1'b0);
    check("rst_wvalid",  bus.wvalid,  1'b0);
    check("rst_bready",  bus.bready,  1'b0);
    check("rst_arvalid", bus.arvalid, 1'b0);
    check("rst_rready",  bus.rready,  1'b0);
    check("rst_done",    txn_done,    1'b0);
    check("rst_error",   error,       1'b0);
    areset = 1'b0;

    // 1: zero-wait slave, exact completion latency.
    b_base = b_cnt;
    push_seq();
    pulse_init();
    repeat (15) @(posedge clk);
    @(negedge clk);
    check("t1_done_at_16", txn_done, 1'b0);
    @(negedge clk);
    check("t1_done_at_17", txn_done, 1'b1);
    check("t1_error", error, 1'b0);
    check("t1_b_count", b_cnt - b_base, 4);
    check_drained("t1");

    // 2: AWREADY three cycles ahead of WREADY.
    aw_delay = 0; w_delay = 3;
    b_base = b_cnt;
    push_seq();
    pulse_init();
    wait_done("t2_done");
    check("t2_error", error, 1'b0);
    check("t2_b_count", b_cnt - b_base, 4);
    check_drained("t2");
    w_delay = 0;

    // 3: slave corrupts word 2 on read-back.
    corrupt_idx = 2;
    push_seq();
    pulse_init();
    rn = 0; n = 0;
    while (rn < 3 && n < 300) begin
      @(negedge clk);
      n++;
      if (bus.rvalid && bus.rready) begin
        rn++;
        if (rn == 3) begin
          check("t3_err_before_bad", error, 1'b0);
          @(negedge clk);
          check("t3_err_after_bad", error, 1'b1);
        end
      end
    end
    check("t3_saw_3_reads", rn, 3);
    wait_done("t3_done");
    check("t3_err_sticky", error, 1'b1);
    check_drained("t3");
    corrupt_idx = -1;

    // 4: error response on write 1, then a clean rerun clears the flags.
    berr_idx = 1;
    r_base = r_cnt;
    push_seq();
    pulse_init();
    wait_done("t4_done");
    check("t4_error", error, 1'b1);
    check("t4_r_count", r_cnt - r_base, 4);
    berr_idx = -1;
    push_seq();
    pulse_init();
    @(negedge clk);
    check("t4_rerun_done_clr", txn_done, 1'b0);
    check("t4_rerun_err_clr", error, 1'b0);
    wait_done("t4_rerun_done");
    check("t4_rerun_error", error, 1'b0);
    check_drained("t4");

    // 5: reset while a read response is being awaited.
    push_seq();
    pulse_init();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.rready !== 1'b1 && n < 300);
    check("t5_reached_rd_data", bus.rready, 1'b1);
    areset = 1'b1;
    @(negedge clk);
    check("t5_awvalid", bus.awvalid, 1'b0);
    check("t5_wvalid",  bus.wvalid,  1'b0);
    check("t5_bready",  bus.bready,  1'b0);
    check("t5_arvalid", bus.arvalid, 1'b0);
    check("t5_rready",  bus.rready,  1'b0);
    check("t5_done",    txn_done,    1'b0);
    check("t5_error",   error,       1'b0);
    areset = 1'b0;
    exp_aw_q.delete(); exp_w_q.delete(); exp_ar_q.delete();
    repeat (2) @(negedge clk);
    push_seq();
    pulse_init();
    wait_done("t5_restart_done");
    check("t5_restart_error", error, 1'b0);
    check_drained("t5");

    // 6: INIT re-raised during WR_RESP and held for 100 cycles.
    aw_base = aw_cnt;
    b_base  = b_cnt;
    push_seq();
    pulse_init();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.bready !== 1'b1 && n < 300);
    check("t6_reached_wr_resp", bus.bready, 1'b1);
    init = 1'b1;
    repeat (100) @(negedge clk);
    init = 1'b0;
    repeat (20) @(negedge clk);
    check("t6_done", txn_done, 1'b1);
    check("t6_error", error, 1'b0);
    check("t6_aw_count", aw_cnt - aw_base, 4);
    check("t6_b_count", b_cnt - b_base, 4);
    check_drained("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_lite_pattern_master.md
Name: axi_lite_pattern_master

Overview:
AXI4-Lite master traffic generator that drives one M0x_AXI port of the MyRiscv IP into the slave memory agent.
- On a rising edge of INIT_AXI_TXN it writes C_M_TRANSACTIONS_NUM words of a deterministic pattern to consecutive addresses.
- It then reads every word back and compares it against the pattern.
- It reports completion on TXN_DONE and any mismatch or error response on ERROR.
- One instance sits behind each master port; each instance is the stage that feeds the slave memory.

Parameters:
C_M_TARGET_SLAVE_BASE_ADDR  32'h4000_0000  byte address of word 0
C_M_AXI_ADDR_WIDTH  32  address bus width
C_M_AXI_DATA_WIDTH  32  data bus width (32 or 64)
C_M_TRANSACTIONS_NUM  4  words written then read (1..256)
C_DATA_SEED  32'hA5A5_0000  pattern base; word i = C_DATA_SEED + i, zero-extended to C_M_AXI_DATA_WIDTH

Ports:
ACLK  in  1  clock; all logic on rising edge
ARESET  in  1  synchronous, active-high reset
INIT_AXI_TXN  in  1  start request, rising-edge detected
TXN_DONE  out  1  sequence complete (level)
ERROR  out  1  sticky mismatch / error-response flag
M_AXI_AWADDR  out  C_M_AXI_ADDR_WIDTH  write address
M_AXI_AWPROT  out  3  constant 3'b000
M_AXI_AWVALID  out  1  write address valid
M_AXI_AWREADY  in  1  write address ready
M_AXI_WDATA  out  C_M_AXI_DATA_WIDTH  write data
M_AXI_WSTRB  out  C_M_AXI_DATA_WIDTH/8  constant all ones
M_AXI_WVALID  out  1  write data valid
M_AXI_WREADY  in  1  write data ready
M_AXI_BRESP  in  2  write response
M_AXI_BVALID  in  1  write response valid
M_AXI_BREADY  out  1  write response ready
M_AXI_ARADDR  out  C_M_AXI_ADDR_WIDTH  read address
M_AXI_ARPROT  out  3  constant 3'b000
M_AXI_ARVALID  out  1  read address valid
M_AXI_ARREADY  in  1  read address ready
M_AXI_RDATA  in  C_M_AXI_DATA_WIDTH  read data
M_AXI_RRESP  in  2  read response
M_AXI_RVALID  in  1  read data valid
M_AXI_RREADY  out  1  read data ready

Behaviour:
- Reset (ARESET=1 at a clock edge): state=IDLE, index=0, all VALID/READY outputs 0, TXN_DONE=0, ERROR=0, start-edge register=0.
- Reset mid-transaction aborts immediately; the interconnect and slave share ARESET.
- Start detection:
  - start = INIT_AXI_TXN & ~init_q, where init_q is INIT_AXI_TXN registered.
  - Honoured only in IDLE or DONE; ignored in all other states.
  - On start: TXN_DONE<=0, ERROR<=0, index<=0, state<=WR_ADDR.
- Address of word i = C_M_TARGET_SLAVE_BASE_ADDR + i*(C_M_AXI_DATA_WIDTH/8), modulo 2^C_M_AXI_ADDR_WIDTH (wraps silently).
- Expected/write data of word i = C_DATA_SEED + i, truncated to the bus width.
- WR_ADDR:
  - AWVALID and WVALID both 1 with AWADDR/WDATA for the current index.
  - Each VALID drops the cycle after its own handshake (VALID&READY). AW and W are independent; either may complete first.
  - VALID and payload are never withdrawn or changed before the handshake.
  - When both have completed, go to WR_RESP.
- WR_RESP:
  - BREADY=1 until BVALID is seen; the handshake takes one cycle.
  - If BRESP[1]=1 then ERROR<=1.
  - If index==N-1: index<=0, go to RD_ADDR. Otherwise index++, go to WR_ADDR.
  - Exactly one write is outstanding at a time.
- RD_ADDR: ARVALID=1 with ARADDR until ARREADY, then go to RD_DATA.
- RD_DATA:
  - RREADY=1 until RVALID.
  - On the handshake, ERROR<=1 if RDATA != expected or RRESP[1]=1.
  - If index==N-1 go to DONE; otherwise index++ and go to RD_ADDR.
- DONE: TXN_DONE=1, held until the next start or reset.
- ERROR is sticky for the whole sequence and visible the cycle after the offending handshake.
- Minimum latency:
  - VALIDs rise the cycle after the edge that samples the start.
  - With an always-ready, zero-wait slave: 2 cycles per write (address/data, then response) and 2 cycles per read.
  - TXN_DONE rises 4N+1 cycles after start is sampled.
- Simultaneous AWREADY/WREADY and BVALID arriving early (before both handshakes): BVALID is not consumed until WR_RESP, because BREADY=0 outside WR_RESP.
- Start held high continuously counts as a single edge only.

Test Plan:
- Reset, then INIT pulse 20 ns, always-ready slave, N=4 -> writes A5A50000..A5A50003 to 40000000/04/08/0C; reads match; TXN_DONE=1, ERROR=0 exactly 17 cycles after start sampled.
- Slave asserts AWREADY 3 cycles before WREADY -> AWVALID drops after its handshake, WVALID stays high with stable data until WREADY; exactly 4 B handshakes; PASS.
- Slave memory corrupts word 2 (returns A5A50012) -> ERROR=1 from the cycle after the 3rd read handshake, stays 1; TXN_DONE=1 after the 4th read.
- BRESP=2'b10 on write 1 -> ERROR=1 sticky; sequence still completes all 4 reads; a second INIT pulse with a clean slave clears ERROR and TXN_DONE, then passes.
- ARESET=1 for one cycle during RD_DATA -> next cycle all VALID/READY=0, TXN_DONE=0, ERROR=0; a new INIT restarts from word 0.
- INIT pulse while in WR_RESP, and INIT held high for 100 cycles -> no restart, exactly one sequence runs.
